ysyx_22040386_alu_exec: RTL and testbench
=========================================

# ysyx_22040386_alu_exec

Multi-cycle integer execute unit for the NPC core. Consumes the 6-bit ALU control code produced by the ALU control decoder together with two XLEN operands, and returns a registered result plus a zero flag under a valid/ready handshake. Logic, shift, compare and add/sub complete in one cycle. MUL uses an iterative shift-add; DIV and REM use an iterative restoring divider. Downstream consumers are writeback and branch resolution.

## Interface
- XLEN, 64, operand/result width; must be a power of two ≥ 8
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, synchronous and active-high
- flush  in  1  synchronous abort of any accepted or in-flight op
- in_valid  in  1  operands and code valid
- in_ready  out  1  unit can accept this cycle
- alu_ctr  in  6  operation code (see Operation)
- src_a  in  XLEN  operand A
- src_b  in  XLEN  operand B
- out_valid  out  1  result valid, held until taken
- out_ready  in  1  consumer takes result
- result  out  XLEN  registered result
- zero  out  1  registered (result == 0)
- busy  out  1  high in MUL or DIV state

## Operation
- Codes:
  - 000000 add
  - 100000 sub
  - 000001 and
  - 000010 or
  - 000011 xor
  - 000100 sll
  - 000101 srl
  - 100110 sra
  - 110111 slt (signed)
  - 100111 sltu
  - 001000 mul
  - 001001 div (signed)
  - 001100 rem (signed)
- Any other code executes as add.
- Shifts use shamt = src_b[log2(XLEN)-1:0]. slt/sltu return 0 or 1 zero-extended. add/sub/mul wrap modulo 2^XLEN. mul returns the low XLEN bits.
- Divide rules (RISC-V):
  - b == 0: div returns all-ones, rem returns a.
  - a == signed-min and b == -1: div returns a, rem returns 0.
  - Otherwise the quotient truncates toward zero and the remainder takes the sign of the dividend.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE: accepting a single-cycle op goes to DONE. Accepting mul loads the multiplicand, multiplier and count=XLEN, then goes to MUL. Accepting div/rem with b==0 or the overflow case writes the special result and goes to DONE. Any other div/rem loads magnitudes and count=XLEN, then goes to DIV.
  - MUL/DIV: each cycle processes one bit and decrements count. When count reaches 1, the final result (sign-corrected for div/rem) is written and the state goes to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE, or directly accept a new op if in_valid (back-to-back).
- in_ready = (state==IDLE) | (state==DONE & out_ready); forced 0 during rst and flush.
- Operands and code are captured at acceptance. Input changes afterward have no effect.
- result, zero, out_valid are stable while out_valid=1 and out_ready=0.

## Timing
- Reset: state=IDLE; out_valid=0, result=0, zero=0, busy=0, count=0.
- Priority: rst > flush > normal operation.
- flush in any state: next cycle state=IDLE, out_valid=0, busy=0, and any result is dropped. A same-cycle in_valid is not accepted. result/zero keep their old value and are don't-care.
- Latency from the accept edge to out_valid high:
  - single-cycle ops: 1 cycle
  - div/rem special cases: 1 cycle
  - mul, normal div/rem: XLEN+1 cycles
- Back-to-back single-cycle ops with out_ready held high: one result per cycle.
- out_ready while out_valid=0 is ignored.
- zero is updated on the same edge as result.

## Test plan
- Reset: assert rst 2 cycles mid-MUL → next cycle out_valid=0, busy=0, in_ready=1. A subsequent add of 5+7 gives result=12 after 1 cycle.
- ALU sweep (XLEN=64), each 1-cycle latency:
  - sub 3-3 → 0, zero=1
  - slt −1,1 → 1
  - sltu −1,1 → 0
  - sra 0x8000…0 by 4 → 0xF800…0
  - sll 1 by 68 → 0x10 (shamt=4)
  - unknown code 0x3F, 2,2 → 4
- mul 0xFFFF_FFFF × 0xFFFF_FFFF → 0xFFFF_FFFE_0000_0001 with out_valid exactly 65 cycles after accept; busy high 64 cycles.
- div/rem:
  - −7/2 → −3, rem −1
  - 7/0 → all-ones (1-cycle latency), rem 7
  - 0x8000…0 / −1 → 0x8000…0, rem 0
- Handshake: hold out_ready=0 for 5 cycles in DONE → result stable, in_ready=0. Then out_ready=1 with in_valid=1 (xor 0xF0,0xFF) → accepted the same cycle, result 0x0F next cycle.
- Flush: flush at cycle 10 of a div → state IDLE next cycle, no out_valid ever for that div. A following or 0x1,0x2 gives 0x3.

Source files
------------

// File: rtl/ysyx_22040386_alu_exec.sv
// rtl/ysyx_22040386_alu_exec.sv - multi-cycle integer execute unit (alu, shift-add mul, restoring div/rem)
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush           abort any accepted or in-flight op
//   in_valid/ready  operand handshake: alu_ctr, src_a, src_b
//   out_valid/ready result handshake: result, zero (held until taken)
//   busy            high while iterating in MUL or DIV
module ysyx_22040386_alu_exec #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [5:0]      alu_ctr,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            busy
);

    localparam int SHW = $clog2(XLEN);
    localparam int CW  = SHW + 1;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b100000;
    localparam logic [5:0] OP_AND  = 6'b000001;
    localparam logic [5:0] OP_OR   = 6'b000010;
    localparam logic [5:0] OP_XOR  = 6'b000011;
    localparam logic [5:0] OP_SLL  = 6'b000100;
    localparam logic [5:0] OP_SRL  = 6'b000101;
    localparam logic [5:0] OP_SRA  = 6'b100110;
    localparam logic [5:0] OP_SLT  = 6'b110111;
    localparam logic [5:0] OP_SLTU = 6'b100111;
    localparam logic [5:0] OP_MUL  = 6'b001000;
    localparam logic [5:0] OP_DIV  = 6'b001001;
    localparam logic [5:0] OP_REM  = 6'b001100;

    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ONES = {XLEN{1'b1}};

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t          state_q;
    logic [CW-1:0]   count_q;
    logic [XLEN-1:0] result_q;
    logic            zero_q;
    logic            out_valid_q;
    logic            busy_q;
    // Shared iteration registers:
    //   MUL: x_q = multiplicand (shifts left), y_q = multiplier (shifts right), p_q = product
    //   DIV: x_q = dividend magnitude shifting into the quotient, y_q = divisor magnitude,
    //        p_q = partial remainder
    logic [XLEN-1:0] x_q;
    logic [XLEN-1:0] y_q;
    logic [XLEN-1:0] p_q;
    logic            neg_q;      // negate final div/rem result
    logic            rem_op_q;   // 1 = rem, 0 = div

    logic            accept;
    logic            is_mul;
    logic            is_div;
    logic            is_rem;
    logic            b_zero;
    logic            div_ovf;
    logic            imm_done;
    logic [XLEN-1:0] imm_res;
    logic [XLEN-1:0] alu_res;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic [XLEN-1:0] mul_p_d;
    logic [XLEN:0]   div_tmp;
    logic            div_ge;
    logic [XLEN-1:0] div_p_d;
    logic [XLEN-1:0] div_x_d;
    logic [XLEN-1:0] div_fin;

    assign in_ready  = !rst && !flush &&
                       ((state_q == S_IDLE) || ((state_q == S_DONE) && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign busy      = busy_q;

    always_comb begin
        shamt = src_b[SHW-1:0];
        case (alu_ctr)
            OP_SUB:  alu_res = src_a - src_b;
            OP_AND:  alu_res = src_a & src_b;
            OP_OR:   alu_res = src_a | src_b;
            OP_XOR:  alu_res = src_a ^ src_b;
            OP_SLL:  alu_res = src_a << shamt;
            OP_SRL:  alu_res = src_a >> shamt;
            OP_SRA:  alu_res = $signed(src_a) >>> shamt;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, src_a < src_b};
            default: alu_res = src_a + src_b;
        endcase

        is_mul  = (alu_ctr == OP_MUL);
        is_div  = (alu_ctr == OP_DIV);
        is_rem  = (alu_ctr == OP_REM);
        b_zero  = (src_b == '0);
        div_ovf = (src_a == SMIN) && (src_b == ONES);

        // div/rem corner cases resolve immediately without iterating
        imm_done = 1'b1;
        imm_res  = alu_res;
        if (is_mul) begin
            imm_done = 1'b0;
        end else if (is_div || is_rem) begin
            if (b_zero) begin
                imm_res = is_rem ? src_a : ONES;
            end else if (div_ovf) begin
                imm_res = is_rem ? '0 : src_a;
            end else begin
                imm_done = 1'b0;
            end
        end

        // SMIN negates to itself, which is also its correct unsigned magnitude
        a_mag = src_a[XLEN-1] ? -src_a : src_a;
        b_mag = src_b[XLEN-1] ? -src_b : src_b;

        mul_p_d = p_q + (y_q[0] ? x_q : '0);

        div_tmp = {p_q, x_q[XLEN-1]};
        div_ge  = (div_tmp >= {1'b0, y_q});
        // true difference is below the divisor, so the low XLEN bits are exact
        div_p_d = div_ge ? (div_tmp[XLEN-1:0] - y_q) : div_tmp[XLEN-1:0];
        div_x_d = {x_q[XLEN-2:0], div_ge};
        if (rem_op_q) begin
            div_fin = neg_q ? -div_p_d : div_p_d;
        end else begin
            div_fin = neg_q ? -div_x_d : div_x_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            p_q         <= '0;
            neg_q       <= 1'b0;
            rem_op_q    <= 1'b0;
        end else if (flush) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else if (accept) begin
            if (imm_done) begin
                result_q    <= imm_res;
                zero_q      <= (imm_res == '0);
                out_valid_q <= 1'b1;
                busy_q      <= 1'b0;
                state_q     <= S_DONE;
            end else if (is_mul) begin
                x_q         <= src_a;
                y_q         <= src_b;
                p_q         <= '0;
                count_q     <= CW'(XLEN);
                out_valid_q <= 1'b0;
                busy_q      <= 1'b1;
                state_q     <= S_MUL;
            end else begin
                x_q         <= a_mag;
                y_q         <= b_mag;
                p_q         <= '0;
                neg_q       <= is_rem ? src_a[XLEN-1] : (src_a[XLEN-1] ^ src_b[XLEN-1]);
                rem_op_q    <= is_rem;
                count_q     <= CW'(XLEN);
                out_valid_q <= 1'b0;
                busy_q      <= 1'b1;
                state_q     <= S_DIV;
            end
        end else begin
            case (state_q)
                S_MUL: begin
                    p_q     <= mul_p_d;
                    x_q     <= x_q << 1;
                    y_q     <= y_q >> 1;
                    count_q <= count_q - CW'(1);
                    if (count_q == CW'(1)) begin
                        result_q    <= mul_p_d;
                        zero_q      <= (mul_p_d == '0);
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_DONE;
                    end
                end
                S_DIV: begin
                    p_q     <= div_p_d;
                    x_q     <= div_x_d;
                    count_q <= count_q - CW'(1);
                    if (count_q == CW'(1)) begin
                        result_q    <= div_fin;
                        zero_q      <= (div_fin == '0);
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22040386_alu_exec.sv
// tb/tb_ysyx_22040386_alu_exec.sv - self-checking bench for ysyx_22040386_alu_exec
module tb_ysyx_22040386_alu_exec;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b100000;
    localparam logic [5:0] OP_AND  = 6'b000001;
    localparam logic [5:0] OP_OR   = 6'b000010;
    localparam logic [5:0] OP_XOR  = 6'b000011;
    localparam logic [5:0] OP_SLL  = 6'b000100;
    localparam logic [5:0] OP_SRL  = 6'b000101;
    localparam logic [5:0] OP_SRA  = 6'b100110;
    localparam logic [5:0] OP_SLT  = 6'b110111;
    localparam logic [5:0] OP_SLTU = 6'b100111;
    localparam logic [5:0] OP_MUL  = 6'b001000;
    localparam logic [5:0] OP_DIV  = 6'b001001;
    localparam logic [5:0] OP_REM  = 6'b001100;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] SMIN = 64'h8000_0000_0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  alu_ctr;
    logic [63:0] src_a;
    logic [63:0] src_b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic        zero;
    logic        busy;

    always #5 clk = ~clk;

    ysyx_22040386_alu_exec #(.XLEN(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctr   (alu_ctr),
        .src_a     (src_a),
        .src_b     (src_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .busy      (busy)
    );

    typedef struct {
        logic [5:0]  c;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] r;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs[NV];

    logic [64:0] sb_q[$];   // {expected zero, expected result}
    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string what, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%h, expected 0x%h", what, act, exp);
    endtask

    task automatic sb_pop_check(input string what);
        logic [64:0] e;
        if (sb_q.size() == 0) begin
            n_total++;
            $display("FAIL %s: output 0x%h with no expected entry", what, result);
        end else begin
            e = sb_q.pop_front();
            chk({what, " result"}, result, e[63:0]);
            chk({what, " zero"}, {63'd0, zero}, {63'd0, e[64]});
        end
    endtask

    // Waits for in_ready, lets the accept edge pass, then scrambles the inputs
    // so that a unit which fails to capture them shows up as a wrong result.
    task automatic issue(input string what, input logic [5:0] c, input logic [63:0] a,
                         input logic [63:0] b);
        int w = 0;
        alu_ctr  = c;
        src_a    = a;
        src_b    = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            n_total++;
            $display("FAIL %s: in_ready never rose (waited %0d cycles, required <300)", what, w);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        alu_ctr  = 6'($urandom);
        src_a    = {$urandom, $urandom};
        src_b    = {$urandom, $urandom};
    endtask

    task automatic run_op(input string what, input logic [5:0] c, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] r, input int exp_lat,
                          output int busy_cnt);
        int lat;
        issue(what, c, a, b);
        sb_q.push_back({(r == 64'd0), r});
        lat      = 0;
        busy_cnt = 0;
        do begin
            @(negedge clk);
            lat++;
            if (busy) busy_cnt++;
        end while (!out_valid && lat < 300);
        chk({what, " latency"}, 64'(lat), 64'(exp_lat));
        if (out_valid) sb_pop_check(what);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int bc;
        int stray;

        vecs[0]  = '{OP_ADD,  64'd5,  64'd7,  64'd12};
        vecs[1]  = '{OP_SUB,  64'd3,  64'd3,  64'd0};
        vecs[2]  = '{OP_SLT,  ONES,   64'd1,  64'd1};
        vecs[3]  = '{OP_SLTU, ONES,   64'd1,  64'd0};
        vecs[4]  = '{OP_SRA,  SMIN,   64'd4,  64'hF800_0000_0000_0000};
        vecs[5]  = '{OP_SLL,  64'd1,  64'd68, 64'h10};
        vecs[6]  = '{6'h3F,   64'd2,  64'd2,  64'd4};
        vecs[7]  = '{OP_AND,  64'hF0F0, 64'hFF00, 64'hF000};
        vecs[8]  = '{OP_OR,   64'hF0, 64'h0F, 64'hFF};
        vecs[9]  = '{OP_XOR,  64'hF0, 64'hFF, 64'h0F};
        vecs[10] = '{OP_SRL,  SMIN,   64'd4,  64'h0800_0000_0000_0000};
        vecs[11] = '{OP_ADD,  ONES,   64'd1,  64'd0};
        vecs[12] = '{OP_SLT,  64'd1,  ONES,   64'd0};
        vecs[13] = '{OP_DIV,  64'd7,  64'd0,  ONES};
        vecs[14] = '{OP_REM,  64'd7,  64'd0,  64'd7};
        vecs[15] = '{OP_DIV,  SMIN,   ONES,   SMIN};
        vecs[16] = '{OP_REM,  SMIN,   ONES,   64'd0};

        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        alu_ctr   = '0;
        src_a     = '0;
        src_b     = '0;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("in_ready during rst", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset result", result, 64'd0);
        chk("reset zero", {63'd0, zero}, 64'd0);
        chk("reset busy", {63'd0, busy}, 64'd0);
        chk("reset in_ready", {63'd0, in_ready}, 64'd1);

        // single-cycle table, streamed back-to-back with out_ready high
        @(posedge clk);
        #1;
        for (int i = 0; i < NV; i++) begin
            alu_ctr  = vecs[i].c;
            src_a    = vecs[i].a;
            src_b    = vecs[i].b;
            in_valid = 1'b1;
            @(negedge clk);
            chk($sformatf("vec%0d in_ready", i), {63'd0, in_ready}, 64'd1);
            if (i > 0) begin
                chk($sformatf("vec%0d out_valid", i - 1), {63'd0, out_valid}, 64'd1);
                sb_pop_check($sformatf("vec%0d", i - 1));
            end
            sb_q.push_back({(vecs[i].r == 64'd0), vecs[i].r});
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk($sformatf("vec%0d out_valid", NV - 1), {63'd0, out_valid}, 64'd1);
        sb_pop_check($sformatf("vec%0d", NV - 1));
        @(posedge clk);
        #1;

        // multi-cycle mul
        run_op("mul ffffffff^2", OP_MUL, 64'hFFFF_FFFF, 64'hFFFF_FFFF,
               64'hFFFF_FFFE_0000_0001, 65, bc);
        chk("mul busy cycles", 64'(bc), 64'd64);
        run_op("mul -3*5", OP_MUL, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5,
               64'hFFFF_FFFF_FFFF_FFF1, 65, bc);

        // multi-cycle div/rem
        run_op("div -7/2", OP_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
               64'hFFFF_FFFF_FFFF_FFFD, 65, bc);
        chk("div busy cycles", 64'(bc), 64'd64);
        run_op("rem -7/2", OP_REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, 65, bc);
        run_op("div 100/-7", OP_DIV, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9,
               64'hFFFF_FFFF_FFFF_FFF2, 65, bc);
        run_op("rem 100/-7", OP_REM, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 65, bc);
        run_op("div 7/0", OP_DIV, 64'd7, 64'd0, ONES, 1, bc);

        // output held while out_ready low, then take + accept in the same cycle
        out_ready = 1'b0;
        issue("hs add", OP_ADD, 64'd9, 64'd1);
        sb_q.push_back({1'b0, 64'd10});
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("hold%0d out_valid", k), {63'd0, out_valid}, 64'd1);
            chk($sformatf("hold%0d result", k), result, 64'd10);
            chk($sformatf("hold%0d zero", k), {63'd0, zero}, 64'd0);
            chk($sformatf("hold%0d in_ready", k), {63'd0, in_ready}, 64'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        alu_ctr   = OP_XOR;
        src_a     = 64'hF0;
        src_b     = 64'hFF;
        in_valid  = 1'b1;
        @(negedge clk);
        chk("hs in_ready", {63'd0, in_ready}, 64'd1);
        sb_pop_check("hs add");
        sb_q.push_back({1'b0, 64'h0F});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("hs xor out_valid", {63'd0, out_valid}, 64'd1);
        sb_pop_check("hs xor");
        @(posedge clk);
        #1;

        // flush in the middle of a div; a same-cycle op must not be taken
        issue("fl div", OP_DIV, 64'd1000, 64'd3);
        repeat (9) @(posedge clk);
        #1;
        flush    = 1'b1;
        alu_ctr  = OP_OR;
        src_a    = 64'd1;
        src_b    = 64'd2;
        in_valid = 1'b1;
        @(negedge clk);
        chk("flush in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("post-flush out_valid", {63'd0, out_valid}, 64'd0);
        chk("post-flush busy", {63'd0, busy}, 64'd0);
        chk("post-flush in_ready", {63'd0, in_ready}, 64'd1);
        stray = 0;
        repeat (80) begin
            @(negedge clk);
            if (out_valid) stray++;
        end
        chk("flushed div stray out_valid", 64'(stray), 64'd0);
        @(posedge clk);
        #1;
        run_op("or after flush", OP_OR, 64'd1, 64'd2, 64'd3, 1, bc);

        // reset in the middle of a mul
        issue("rst mul", OP_MUL, 64'd3, 64'd5);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst-mul out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst-mul busy", {63'd0, busy}, 64'd0);
        chk("rst-mul in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        run_op("add after rst", OP_ADD, 64'd5, 64'd7, 64'd12, 1, bc);

        repeat (3) @(posedge clk);
        chk("scoreboard drained", 64'(sb_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
